// File: rtl/demux_pkg.sv
// demux_pkg: state encoding and helpers shared by the guarded bus demultiplexer.
package demux_pkg;

    // Widest bus the idle-word helper can build.
    localparam int unsigned MAX_BUS_W = 256;

    // Guard intervals are counted in an 8-bit timer (0..255 cycles).
    localparam int unsigned TIMER_W = 8;

    // OFF: nothing routed. GUARD: break-before-make gap. ON: one channel routed.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } demux_state_t;

    // Builds the idle word for a channel: lvl copied into the low 'width' bits.
    // The caller casts the result down to its own bus width.
    function automatic logic [MAX_BUS_W-1:0] unsel_word(input int unsigned width,
                                                        input logic lvl);
        logic [MAX_BUS_W-1:0] mask;
        mask = ~({MAX_BUS_W{1'b1}} << width);
        return {MAX_BUS_W{lvl}} & mask;
    endfunction

endpackage

// File: rtl/demux_n_guarded_if.sv
// demux_n_guarded_if: bus and select handshake between the SPI engine (master)
// and the guarded demultiplexer (slave).
interface demux_n_guarded_if #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned NUM_CH    = 4
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    logic [BUS_WIDTH-1:0]        in;
    logic                        sel_req;
    logic [CH_W-1:0]             sel_ch;
    logic                        off_req;
    logic                        sel_ack;
    logic                        sel_err;
    logic                        busy;
    logic [CH_W-1:0]             active_ch;
    logic                        out_en;
    logic [NUM_CH*BUS_WIDTH-1:0] out;

    modport master (
        output in, sel_req, sel_ch, off_req,
        input  sel_ack, sel_err, busy, active_ch, out_en, out
    );

    modport slave (
        input  in, sel_req, sel_ch, off_req,
        output sel_ack, sel_err, busy, active_ch, out_en, out
    );

endinterface

// File: rtl/guard_timer.sv
// guard_timer: loadable down-counter that times the all-idle gap between channels.
// It stops at zero rather than wrapping, so a stray enable cannot restart a guard.
module guard_timer
    import demux_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               en_i,
    output logic [TIMER_W-1:0] count_o,
    output logic               zero_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Load has priority over counting; counting saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Counter register, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/demux_n_guarded.sv
// demux_n_guarded: registered 1-to-NUM_CH bus demultiplexer with break-before-make
// switching. A channel change passes through GUARD, where every channel sits at the
// idle level, so two ports are never driven in the same cycle.
module demux_n_guarded
    import demux_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned NUM_CH       = 4,
    parameter logic        UNSEL_LVL    = 1'b0,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    demux_n_guarded_if.slave bus
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam logic [BUS_WIDTH-1:0] UNSEL_WORD =
        BUS_WIDTH'(unsel_word(BUS_WIDTH, UNSEL_LVL));
    localparam logic [TIMER_W-1:0] GUARD_LOAD = TIMER_W'(GUARD_CYCLES);

    demux_state_t        state_q;
    demux_state_t        state_d;
    logic [CH_W-1:0]     activeCh_q;
    logic [CH_W-1:0]     activeCh_d;
    logic                selAck_q;
    logic                selAck_d;
    logic                selErr_q;
    logic                selErr_d;

    logic                tmrLoad;
    logic [TIMER_W-1:0]  tmrLoadVal;
    logic                tmrEn;
    logic [TIMER_W-1:0]  tmrCount;
    logic                tmrZero;

    logic                chLegal;
    logic                guardDone;
    logic [NUM_CH*BUS_WIDTH-1:0] outFlat;

    // A request naming a channel beyond NUM_CH-1 is rejected with sel_err.
    assign chLegal = (32'(bus.sel_ch) < NUM_CH);

    // The guard ends on the edge where the timer steps from 1 to 0; zero is a
    // safety net so GUARD can never stall.
    assign guardDone = (tmrCount == TIMER_W'(1)) || tmrZero;

    guard_timer u_guard_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (tmrLoad),
        .load_val_i (tmrLoadVal),
        .en_i       (tmrEn),
        .count_o    (tmrCount),
        .zero_o     (tmrZero)
    );

    // Next-state logic: off_req wins, then an illegal channel, then a select.
    // While in GUARD only off_req is honoured; other requests are dropped.
    always_comb begin
        state_d    = state_q;
        activeCh_d = activeCh_q;
        selAck_d   = 1'b0;
        selErr_d   = 1'b0;
        case (state_q)
            GUARD: begin
                if (bus.off_req) begin
                    state_d = OFF;
                end else if (guardDone) begin
                    state_d  = ON;
                    selAck_d = 1'b1;
                end
            end
            OFF, ON: begin
                if (bus.off_req) begin
                    state_d = OFF;
                end else if (bus.sel_req) begin
                    if (!chLegal) begin
                        selErr_d = 1'b1;
                    end else if ((state_q == ON) && (bus.sel_ch == activeCh_q)) begin
                        selAck_d = 1'b1;
                    end else begin
                        activeCh_d = bus.sel_ch;
                        if (GUARD_CYCLES == 0) begin
                            state_d  = ON;
                            selAck_d = 1'b1;
                        end else begin
                            state_d = GUARD;
                        end
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

    // Timer is loaded on entry to GUARD and cleared whenever GUARD is left,
    // including an abort by off_req, so it always idles at zero.
    always_comb begin
        tmrLoad    = (state_d == GUARD) != (state_q == GUARD);
        tmrLoadVal = (state_d == GUARD) ? GUARD_LOAD : '0;
        tmrEn      = (state_q == GUARD);
    end

    // Control registers: state, routed channel and the two one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= OFF;
            activeCh_q <= '0;
            selAck_q   <= 1'b0;
            selErr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            activeCh_q <= activeCh_d;
            selAck_q   <= selAck_d;
            selErr_q   <= selErr_d;
        end
    end

    // One output register per channel. Routing follows the next state, so the old
    // channel drops to idle on the same edge that leaves ON, and data appears on
    // the edge that enters ON.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [BUS_WIDTH-1:0] chan_q;
        logic [BUS_WIDTH-1:0] chan_d;

        // Route the input only to the channel that will be active next cycle.
        always_comb begin
            chan_d = UNSEL_WORD;
            if ((state_d == ON) && (32'(activeCh_d) == k)) begin
                chan_d = bus.in;
            end
        end

        // Channel register resets straight to the idle level, with no clock needed.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                chan_q <= UNSEL_WORD;
            end else begin
                chan_q <= chan_d;
            end
        end

        assign outFlat[k*BUS_WIDTH +: BUS_WIDTH] = chan_q;
    end

    assign bus.out       = outFlat;
    assign bus.sel_ack   = selAck_q;
    assign bus.sel_err   = selErr_q;
    assign bus.busy      = (state_q == GUARD);
    assign bus.out_en    = (state_q == ON);
    assign bus.active_ch = activeCh_q;

endmodule

// File: tb/tb_demux_n_guarded.sv
// tb_demux_n_guarded: three demultiplexer variants driven by one shared stimulus
// stream and checked against a behavioural model of the select/guard rules.
//   dut0: 4 channels, idle 0, guard 2   dut1: 3 channels, idle 1, guard 1
//   dut2: 2 channels, idle 0, guard 0
module tb_demux_n_guarded;

    localparam int NDUT = 3;
    localparam int NCH [NDUT] = '{4, 3, 2};
    localparam int GCY [NDUT] = '{2, 1, 0};
    localparam logic [7:0] IDLE_BYTE [NDUT] = '{8'h00, 8'hFF, 8'h00};
    localparam int M_IDLE   = 0;
    localparam int M_WAIT   = 1;
    localparam int M_ROUTED = 2;

    logic       clk    = 1'b0;
    logic       rstN   = 1'b1;
    logic [7:0] inData = 8'h00;
    logic       selReq = 1'b0;
    logic       offReq = 1'b0;
    logic [1:0] selCh  = 2'd0;

    int checks = 0;
    int errors = 0;

    int          mMode [NDUT];
    int          mCh   [NDUT];
    int          mLeft [NDUT];
    logic        mAck  [NDUT];
    logic        mErr  [NDUT];
    logic [31:0] mOut  [NDUT];

    always #5 clk = ~clk;

    demux_n_guarded_if #(.BUS_WIDTH(8), .NUM_CH(4)) ifA ();
    demux_n_guarded_if #(.BUS_WIDTH(8), .NUM_CH(3)) ifB ();
    demux_n_guarded_if #(.BUS_WIDTH(8), .NUM_CH(2)) ifC ();

    assign ifA.in = inData;  assign ifA.sel_req = selReq;
    assign ifA.off_req = offReq;  assign ifA.sel_ch = selCh;
    assign ifB.in = inData;  assign ifB.sel_req = selReq;
    assign ifB.off_req = offReq;  assign ifB.sel_ch = selCh;
    assign ifC.in = inData;  assign ifC.sel_req = selReq;
    assign ifC.off_req = offReq;  assign ifC.sel_ch = selCh[0];

    demux_n_guarded #(.BUS_WIDTH(8), .NUM_CH(4), .UNSEL_LVL(1'b0), .GUARD_CYCLES(2))
        dutA (.clk(clk), .reset_n(rstN), .bus(ifA));
    demux_n_guarded #(.BUS_WIDTH(8), .NUM_CH(3), .UNSEL_LVL(1'b1), .GUARD_CYCLES(1))
        dutB (.clk(clk), .reset_n(rstN), .bus(ifB));
    demux_n_guarded #(.BUS_WIDTH(8), .NUM_CH(2), .UNSEL_LVL(1'b0), .GUARD_CYCLES(0))
        dutC (.clk(clk), .reset_n(rstN), .bus(ifC));

    logic [31:0] obsOut [NDUT];
    logic        obsAck [NDUT];
    logic        obsErr [NDUT];
    logic        obsBusy[NDUT];
    logic        obsEn  [NDUT];
    logic [1:0]  obsCh  [NDUT];

    assign obsOut[0] = ifA.out;             assign obsOut[1] = {8'h00, ifB.out};
    assign obsOut[2] = {16'h0000, ifC.out};
    assign obsAck[0] = ifA.sel_ack;  assign obsAck[1] = ifB.sel_ack;  assign obsAck[2] = ifC.sel_ack;
    assign obsErr[0] = ifA.sel_err;  assign obsErr[1] = ifB.sel_err;  assign obsErr[2] = ifC.sel_err;
    assign obsBusy[0] = ifA.busy;    assign obsBusy[1] = ifB.busy;    assign obsBusy[2] = ifC.busy;
    assign obsEn[0] = ifA.out_en;    assign obsEn[1] = ifB.out_en;    assign obsEn[2] = ifC.out_en;
    assign obsCh[0] = ifA.active_ch; assign obsCh[1] = ifB.active_ch;
    assign obsCh[2] = {1'b0, ifC.active_ch};

    // Model reset: nothing routed, every real channel at its idle byte.
    function automatic void modelReset();
        for (int d = 0; d < NDUT; d++) begin
            mMode[d] = M_IDLE;
            mCh[d]   = 0;
            mLeft[d] = 0;
            mAck[d]  = 1'b0;
            mErr[d]  = 1'b0;
            mOut[d]  = '0;
            for (int k = 0; k < NCH[d]; k++) mOut[d][k*8 +: 8] = IDLE_BYTE[d];
        end
    endfunction

    // Model clock edge: applies the request rules to the inputs seen at the edge.
    function automatic void modelStep();
        for (int d = 0; d < NDUT; d++) begin
            int req;
            req = (NCH[d] == 2) ? int'(selCh[0]) : int'(selCh);
            mAck[d] = 1'b0;
            mErr[d] = 1'b0;
            if (offReq) begin
                mMode[d] = M_IDLE;
            end else if (mMode[d] == M_WAIT) begin
                mLeft[d] = mLeft[d] - 1;
                if (mLeft[d] == 0) begin
                    mMode[d] = M_ROUTED;
                    mAck[d]  = 1'b1;
                end
            end else if (selReq) begin
                if (req >= NCH[d]) begin
                    mErr[d] = 1'b1;
                end else if (mMode[d] == M_ROUTED && req == mCh[d]) begin
                    mAck[d] = 1'b1;
                end else begin
                    mCh[d] = req;
                    if (GCY[d] == 0) begin
                        mMode[d] = M_ROUTED;
                        mAck[d]  = 1'b1;
                    end else begin
                        mMode[d] = M_WAIT;
                        mLeft[d] = GCY[d];
                    end
                end
            end
            mOut[d] = '0;
            for (int k = 0; k < NCH[d]; k++)
                mOut[d][k*8 +: 8] = (mMode[d] == M_ROUTED && k == mCh[d]) ? inData : IDLE_BYTE[d];
        end
    endfunction

    // One clock: the model sees the same inputs as the DUTs, then settle 1 ns.
    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // No two channels of any variant may carry non-idle data in the same cycle.
    always @(negedge clk) begin
        if (rstN) begin
            for (int d = 0; d < NDUT; d++) begin
                int live;
                live = 0;
                for (int k = 0; k < NCH[d]; k++)
                    if (obsOut[d][k*8 +: 8] !== IDLE_BYTE[d]) live++;
                checks++;
                if (live > 1) begin
                    errors++;
                    $display("[TB] FAIL invariant dut%0d: %0d live channels, expected at most 1", d, live);
                end
            end
        end
    end

    task automatic test_reset();
        #1 rstN = 1'b0;
        modelReset();
        #2;
        checks++; if (ifA.out !== 32'h0) begin errors++; $display("[TB] FAIL reset_outA: got %h expected 00000000", ifA.out); end
        checks++; if (ifB.out !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL reset_outB: got %h expected ffffff", ifB.out); end
        checks++; if (ifA.out_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_en: got %b expected 0", ifA.out_en); end
        checks++; if (ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", ifA.busy); end
        checks++; if (ifA.active_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch: got %0d expected 0", ifA.active_ch); end
        checks++; if (ifA.sel_ack !== 1'b0 || ifA.sel_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulses: got ack %b err %b expected 0 0", ifA.sel_ack, ifA.sel_err); end
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        tick(); tick();
        checks++; if (ifA.out !== 32'h0 || ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got out %h busy %b expected 0 0", ifA.out, ifA.busy); end
    endtask

    task automatic test_select_from_off();
        inData = 8'h5A; selReq = 1'b1; selCh = 2'd2;
        tick();
        selReq = 1'b0;
        checks++; if (ifA.busy !== 1'b1 || ifA.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL sel_c1: got busy %b ack %b expected 1 0", ifA.busy, ifA.sel_ack); end
        checks++; if (ifA.out !== 32'h0) begin errors++; $display("[TB] FAIL sel_c1_out: got %h expected 00000000", ifA.out); end
        tick();
        checks++; if (ifA.busy !== 1'b1 || ifA.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL sel_c2: got busy %b ack %b expected 1 0", ifA.busy, ifA.sel_ack); end
        tick();
        checks++; if (ifA.sel_ack !== 1'b1 || ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL sel_c3_ack: got ack %b busy %b expected 1 0", ifA.sel_ack, ifA.busy); end
        checks++; if (ifA.out_en !== 1'b1 || ifA.active_ch !== 2'd2) begin errors++; $display("[TB] FAIL sel_c3_ch: got en %b ch %0d expected 1 2", ifA.out_en, ifA.active_ch); end
        inData = 8'hA5;
        tick();
        checks++; if (ifA.out !== 32'h00A50000) begin errors++; $display("[TB] FAIL sel_data: got %h expected 00a50000", ifA.out); end
        checks++; if (ifA.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL sel_ack_width: got %b expected 0", ifA.sel_ack); end
    endtask

    task automatic test_channel_change();
        inData = 8'h3C; selReq = 1'b1; selCh = 2'd1;
        tick();
        selReq = 1'b0;
        checks++; if (ifA.out !== 32'h0 || ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL chg_break: got out %h busy %b expected 00000000 1", ifA.out, ifA.busy); end
        tick();
        checks++; if (ifA.out !== 32'h0 || ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL chg_gap: got out %h busy %b expected 00000000 1", ifA.out, ifA.busy); end
        tick();
        checks++; if (ifA.sel_ack !== 1'b1 || ifA.active_ch !== 2'd1) begin errors++; $display("[TB] FAIL chg_ack: got ack %b ch %0d expected 1 1", ifA.sel_ack, ifA.active_ch); end
        checks++; if (ifA.out !== 32'h00003C00) begin errors++; $display("[TB] FAIL chg_make: got %h expected 00003c00", ifA.out); end
    endtask

    task automatic test_reselect();
        inData = 8'h11; selReq = 1'b1; selCh = 2'd1;
        tick();
        selReq = 1'b0;
        checks++; if (ifA.sel_ack !== 1'b1 || ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL resel_ack: got ack %b busy %b expected 1 0", ifA.sel_ack, ifA.busy); end
        checks++; if (ifA.out !== 32'h00001100) begin errors++; $display("[TB] FAIL resel_data: got %h expected 00001100", ifA.out); end
        inData = 8'h22;
        tick();
        checks++; if (ifA.out !== 32'h00002200 || ifA.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL resel_cont: got out %h ack %b expected 00002200 0", ifA.out, ifA.sel_ack); end
    endtask

    task automatic test_off_with_sel();
        selReq = 1'b1; selCh = 2'd3; offReq = 1'b1;
        tick();
        selReq = 1'b0; offReq = 1'b0;
        checks++; if (ifA.out_en !== 1'b0 || ifA.sel_ack !== 1'b0 || ifA.busy !== 1'b0) begin errors++; $display("[TB] FAIL off_state: got en %b ack %b busy %b expected 0 0 0", ifA.out_en, ifA.sel_ack, ifA.busy); end
        checks++; if (ifA.out !== 32'h0) begin errors++; $display("[TB] FAIL off_out: got %h expected 00000000", ifA.out); end
        tick();
        checks++; if (ifA.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL off_noack: got %b expected 0", ifA.sel_ack); end
    endtask

    task automatic test_illegal_channel();
        inData = 8'h77; selReq = 1'b1; selCh = 2'd0;
        tick();
        selReq = 1'b0;
        repeat (3) tick();
        selReq = 1'b1; selCh = 2'd3;
        tick();
        selReq = 1'b0;
        checks++; if (ifB.sel_err !== 1'b1 || ifB.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL illegal_pulse: got err %b ack %b expected 1 0", ifB.sel_err, ifB.sel_ack); end
        checks++; if (ifB.out_en !== 1'b1 || ifB.busy !== 1'b0 || ifB.active_ch !== 2'd0) begin errors++; $display("[TB] FAIL illegal_state: got en %b busy %b ch %0d expected 1 0 0", ifB.out_en, ifB.busy, ifB.active_ch); end
        checks++; if (ifB.out !== 24'hFFFF77) begin errors++; $display("[TB] FAIL illegal_out: got %h expected ffff77", ifB.out); end
        checks++; if (ifA.sel_err !== 1'b0 || ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL legal_ch3: got err %b busy %b expected 0 1", ifA.sel_err, ifA.busy); end
        tick();
        checks++; if (ifB.sel_err !== 1'b0) begin errors++; $display("[TB] FAIL illegal_width: got %b expected 0", ifB.sel_err); end
    endtask

    task automatic test_guard_off();
        offReq = 1'b1;
        tick();
        offReq = 1'b0; selReq = 1'b1; selCh = 2'd1;
        tick();
        selReq = 1'b0;
        checks++; if (ifA.busy !== 1'b1) begin errors++; $display("[TB] FAIL goff_busy: got %b expected 1", ifA.busy); end
        offReq = 1'b1;
        tick();
        offReq = 1'b0;
        checks++; if (ifA.busy !== 1'b0 || ifA.out_en !== 1'b0 || ifA.out !== 32'h0) begin errors++; $display("[TB] FAIL goff_abort: got busy %b en %b out %h expected 0 0 00000000", ifA.busy, ifA.out_en, ifA.out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ifA.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL goff_noack%0d: got %b expected 0", i, ifA.sel_ack); end
        end
    endtask

    task automatic test_reset_mid_guard();
        inData = 8'h99; selReq = 1'b1; selCh = 2'd0;
        tick();
        selReq = 1'b0;
        repeat (3) tick();
        selReq = 1'b1; selCh = 2'd1;
        tick();
        selReq = 1'b0;
        checks++; if (ifA.busy !== 1'b1 || ifB.busy !== 1'b1) begin errors++; $display("[TB] FAIL mid_pre: got busyA %b busyB %b expected 1 1", ifA.busy, ifB.busy); end
        checks++; if (ifC.out !== 16'h9900) begin errors++; $display("[TB] FAIL mid_preC: got %h expected 9900", ifC.out); end
        #2 rstN = 1'b0;
        modelReset();
        #1;
        checks++; if (ifA.busy !== 1'b0 || ifB.busy !== 1'b0 || ifA.out !== 32'h0) begin errors++; $display("[TB] FAIL mid_abort: got busyA %b busyB %b outA %h expected 0 0 00000000", ifA.busy, ifB.busy, ifA.out); end
        checks++; if (ifB.out !== 24'hFFFFFF) begin errors++; $display("[TB] FAIL mid_outB: got %h expected ffffff", ifB.out); end
        checks++; if (ifC.out !== 16'h0000 || ifC.out_en !== 1'b0) begin errors++; $display("[TB] FAIL mid_outC: got out %h en %b expected 0000 0", ifC.out, ifC.out_en); end
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ifA.sel_ack !== 1'b0 || ifB.sel_ack !== 1'b0) begin errors++; $display("[TB] FAIL mid_noack%0d: got ackA %b ackB %b expected 0 0", i, ifA.sel_ack, ifB.sel_ack); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            offReq = (r < 8);
            selReq = (r >= 8 && r < 45);
            selCh  = 2'($urandom_range(0, 3));
            inData = 8'($urandom);
            tick();
            for (int d = 0; d < NDUT; d++) begin
                checks++; if (obsAck[d] !== mAck[d]) begin errors++; $display("[TB] FAIL rnd_ack dut%0d cyc%0d: got %b expected %b", d, n, obsAck[d], mAck[d]); end
                checks++; if (obsErr[d] !== mErr[d]) begin errors++; $display("[TB] FAIL rnd_err dut%0d cyc%0d: got %b expected %b", d, n, obsErr[d], mErr[d]); end
                checks++; if (obsBusy[d] !== (mMode[d] == M_WAIT)) begin errors++; $display("[TB] FAIL rnd_busy dut%0d cyc%0d: got %b expected %b", d, n, obsBusy[d], mMode[d] == M_WAIT); end
                checks++; if (obsEn[d] !== (mMode[d] == M_ROUTED)) begin errors++; $display("[TB] FAIL rnd_en dut%0d cyc%0d: got %b expected %b", d, n, obsEn[d], mMode[d] == M_ROUTED); end
                checks++; if (obsOut[d] !== mOut[d]) begin errors++; $display("[TB] FAIL rnd_out dut%0d cyc%0d: got %h expected %h", d, n, obsOut[d], mOut[d]); end
                if (mMode[d] == M_ROUTED) begin
                    checks++; if (int'(obsCh[d]) != mCh[d]) begin errors++; $display("[TB] FAIL rnd_ch dut%0d cyc%0d: got %0d expected %0d", d, n, obsCh[d], mCh[d]); end
                end
            end
        end
        selReq = 1'b0;
        offReq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_select_from_off();
        test_channel_change();
        test_reselect();
        test_off_with_sel();
        test_illegal_channel();
        test_guard_off();
        test_reset_mid_guard();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete within 200000 ns");
        $fatal(1, "[TB] timeout");
    end

endmodule
